// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - framed byte-stream boot loader writing 32-bit words into the instruction ROM
// Frame: MAGIC, len_lo, len_hi, 4*N data bytes (LSB first), 8-bit additive checksum.
module rom_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          MAX_WORDS   = 512,
   parameter logic [7:0]  MAGIC       = 8'hA5,
   parameter int          TIMEOUT_CYC = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        we_o,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   output logic        cpu_hold_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
   } state_t;

   state_t         state_q, state_d;
   logic [15:0]    len_q, len_d;
   logic [15:0]    word_idx_q, word_idx_d;
   logic [7:0]     sum_q, sum_d;
   logic [1:0]     byte_cnt_q, byte_cnt_d;
   logic [23:0]    shift_q, shift_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           we_q, we_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    data_q, data_d;
   logic           accept;
   logic           in_frame;

   assign rx_ready_o = 1'b1;
   assign accept     = rx_valid_i & rx_ready_o;
   assign in_frame   = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                       (state_q == S_DATA) || (state_q == S_CHK);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      sum_d      = sum_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      timer_d    = '0;
      we_d       = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;

      case (state_q)
         S_LEN0: if (accept) begin
            len_d[7:0] = rx_data_i;
            sum_d      = sum_q + rx_data_i;
            state_d    = S_LEN1;
         end
         S_LEN1: if (accept) begin
            len_d[15:8] = rx_data_i;
            sum_d       = sum_q + rx_data_i;
            if ({rx_data_i, len_q[7:0]} > 16'(MAX_WORDS))
               state_d = S_ERR;
            else if ({rx_data_i, len_q[7:0]} == 16'd0)
               state_d = S_CHK;
            else
               state_d = S_DATA;
         end
         S_DATA: if (accept) begin
            sum_d      = sum_q + rx_data_i;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
               we_d       = 1'b1;
               addr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
               data_d     = {rx_data_i, shift_q};
               word_idx_d = word_idx_q + 16'd1;
               if (word_idx_q == len_q - 16'd1)
                  state_d = S_CHK;
            end else begin
               shift_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
            end
         end
         S_CHK: if (accept) begin
            state_d = (rx_data_i == sum_q) ? S_DONE : S_ERR;
         end
         default: if (accept && rx_data_i == MAGIC) begin
            state_d    = S_LEN0;
            sum_d      = 8'd0;
            word_idx_d = 16'd0;
            byte_cnt_d = 2'd0;
         end
      endcase

      // Idle-gap watchdog; only runs when no byte arrives, so it never races an accept.
      if (in_frame && !accept) begin
         if (timer_q == TW'(TIMEOUT_CYC - 1))
            state_d = S_ERR;
         else
            timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         word_idx_q <= '0;
         sum_q      <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         timer_q    <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         sum_q      <= sum_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         timer_q    <= timer_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   assign we_o       = we_q;
   assign addr_o     = addr_q;
   assign data_o     = data_q;
   assign busy_o     = in_frame;
   assign done_o     = (state_q == S_DONE);
   assign err_o      = (state_q == S_ERR);
   assign cpu_hold_o = in_frame || (state_q == S_ERR);

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed table-driven bench for rom_loader
module tb_rom_loader;

   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready, we, cpu_hold, busy, done, err;
   logic [31:0] addr, data;

   rom_loader #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
      .we_o(we), .addr_o(addr), .data_o(data),
      .cpu_hold_o(cpu_hold), .busy_o(busy), .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   int          wr_n = 0;
   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];
   int          wr_cyc  [64];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (we && wr_n < 64) begin
         wr_addr[wr_n] <= addr;
         wr_data[wr_n] <= data;
         wr_cyc[wr_n]  <= cyc;
         wr_n          <= wr_n + 1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick(1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " rx_ready"}, 32'(rx_ready), 32'd1);
      chk({tag, " we"},       32'(we),       32'd0);
      chk({tag, " addr"},     addr,          32'd0);
      chk({tag, " data"},     data,          32'd0);
      chk({tag, " hold"},     32'(cpu_hold), 32'd0);
      chk({tag, " busy"},     32'(busy),     32'd0);
      chk({tag, " done"},     32'(done),     32'd0);
      chk({tag, " err"},      32'(err),      32'd0);
   endtask

   // Frame bytes are written in wire order, first byte most significant.
   typedef struct {
      string        name;
      int           n;
      logic [127:0] fr;
      logic         done, err, hold;
      int           nwr;
      logic [31:0]  d0, d1;
   } vec_t;

   vec_t tbl [6];

   task automatic send_frame(input logic [127:0] fr, input int n);
      for (int i = 0; i < n; i++) send(fr[8*(n-1-i) +: 8]);
      rx_valid = 1'b0;
   endtask

   int base;

   initial begin
      tbl[0] = '{"good",     12, 128'hA5_02_00_13_00_00_00_6F_00_00_00_84,
                 1'b1, 1'b0, 1'b0, 2, 32'h0000_0013, 32'h0000_006F};
      tbl[1] = '{"badsum",   12, 128'hA5_02_00_13_00_00_00_6F_00_00_00_85,
                 1'b0, 1'b1, 1'b1, 2, 32'h0000_0013, 32'h0000_006F};
      tbl[2] = '{"toolong",   3, 128'hA5_01_02,
                 1'b0, 1'b1, 1'b1, 0, 32'h0, 32'h0};
      tbl[3] = '{"garbage",  15, 128'h00_FF_13_A5_02_00_13_00_00_00_6F_00_00_00_84,
                 1'b1, 1'b0, 1'b0, 2, 32'h0000_0013, 32'h0000_006F};
      tbl[4] = '{"zerolen",   4, 128'hA5_00_00_00,
                 1'b1, 1'b0, 1'b0, 0, 32'h0, 32'h0};
      tbl[5] = '{"magicdata", 8, 128'hA5_01_00_A5_A5_A5_A5_95,
                 1'b1, 1'b0, 1'b0, 1, 32'hA5A5_A5A5, 32'h0};

      tick(2);
      rst = 1'b0;
      tick(1);
      chk_reset_outs("reset");

      for (int r = 0; r < 6; r++) begin
         do_reset();
         base = wr_n;
         send_frame(tbl[r].fr, tbl[r].n);
         tick(3);
         chk({tbl[r].name, " done"}, 32'(done),     32'(tbl[r].done));
         chk({tbl[r].name, " err"},  32'(err),      32'(tbl[r].err));
         chk({tbl[r].name, " hold"}, 32'(cpu_hold), 32'(tbl[r].hold));
         chk({tbl[r].name, " busy"}, 32'(busy),     32'd0);
         chk({tbl[r].name, " nwr"},  32'(wr_n - base), 32'(tbl[r].nwr));
         if (tbl[r].nwr >= 1 && wr_n > base) begin
            chk({tbl[r].name, " a0"}, wr_addr[base], 32'h0);
            chk({tbl[r].name, " d0"}, wr_data[base], tbl[r].d0);
         end
         if (tbl[r].nwr >= 2 && wr_n > base + 1) begin
            chk({tbl[r].name, " a1"}, wr_addr[base+1], 32'h4);
            chk({tbl[r].name, " d1"}, wr_data[base+1], tbl[r].d1);
         end
      end

      // hold rises the cycle after MAGIC; oversize length errors right after len_hi
      do_reset();
      send(8'hA5);
      chk("hold after magic", 32'(cpu_hold), 32'd1);
      chk("busy after magic", 32'(busy), 32'd1);
      send(8'h01);
      send(8'h02);
      rx_valid = 1'b0;
      chk("oversize err now", 32'(err), 32'd1);

      // Idle timeout mid-word, then recovery from ERR
      do_reset();
      base = wr_n;
      send_frame(128'hA5_01_00_11_22, 5);
      tick(TMO - 1);
      chk("tmo not yet err", 32'(err), 32'd0);
      chk("tmo not yet busy", 32'(busy), 32'd1);
      tick(1);
      chk("tmo err", 32'(err), 32'd1);
      chk("tmo hold", 32'(cpu_hold), 32'd1);
      chk("tmo no write", 32'(wr_n - base), 32'd0);
      send_frame(128'hA5_02_00_13_00_00_00_6F_00_00_00_84, 12);
      tick(2);
      chk("tmo recover done", 32'(done), 32'd1);
      chk("tmo recover err", 32'(err), 32'd0);
      chk("tmo recover nwr", 32'(wr_n - base), 32'd2);

      // Reset after the 3rd data byte, then a back-to-back 3-word frame
      do_reset();
      base = wr_n;
      send_frame(128'hA5_01_00_11_22_33, 6);
      rst = 1'b1;
      #1;
      chk_reset_outs("midrst");
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("midrst no write", 32'(wr_n - base), 32'd0);
      send_frame(128'hA5_03_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_51, 16);
      tick(2);
      chk("b2b done", 32'(done), 32'd1);
      chk("b2b nwr", 32'(wr_n - base), 32'd3);
      if (wr_n >= base + 3) begin
         chk("b2b d0", wr_data[base],   32'h0403_0201);
         chk("b2b d1", wr_data[base+1], 32'h0807_0605);
         chk("b2b a2", wr_addr[base+2], 32'h8);
         chk("b2b d2", wr_data[base+2], 32'h0C0B_0A09);
         chk("b2b gap01", 32'(wr_cyc[base+1] - wr_cyc[base]),   32'd4);
         chk("b2b gap12", 32'(wr_cyc[base+2] - wr_cyc[base+1]), 32'd4);
      end
      chk("hold addr", addr, 32'h8);
      chk("hold data", data, 32'h0C0B_0A09);
      chk("we idle", 32'(we), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
